// File: rtl/seg_scan_reader.sv
// seg_scan_reader: recovers BCD digits from a multiplexed active-low 7-segment bus,
// committing a digit only after its {index, pattern} sample has held for STABLE_CYCLES.
module seg_scan_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          segments,
    input  logic [DIGITS-1:0]   anodes,
    output logic [4*DIGITS-1:0] digits,
    output logic [DIGITS-1:0]   digit_valid,
    output logic                update,
    output logic [2:0]          update_idx,
    output logic                err
);
    typedef enum logic [1:0] {IDLE, TRACK, COMMITTED} state_t;
    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    state_t              state_q;
    logic [6:0]          seg_q, cand_seg_q;
    logic [DIGITS-1:0]   an_q;
    logic [2:0]          cand_idx_q;
    logic [7:0]          cnt_q;
    logic [4*DIGITS-1:0] digits_q;
    logic [DIGITS-1:0]   valid_q;
    logic                update_q, err_q;
    logic [2:0]          idx_q;
    logic [3:0]          zeros;
    logic [2:0]          samp_idx;
    logic                samp_ok, same;
    logic [4:0]          dec;

    // bit 4 flags an illegal pattern, bits 3:0 carry the value (F when illegal)
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F:   decode = 5'h00;
            7'h06:   decode = 5'h01;
            7'h5B:   decode = 5'h02;
            7'h4F:   decode = 5'h03;
            7'h66:   decode = 5'h04;
            7'h6D:   decode = 5'h05;
            7'h7D:   decode = 5'h06;
            7'h07:   decode = 5'h07;
            7'h7F:   decode = 5'h08;
            7'h6F:   decode = 5'h09;
            default: decode = 5'h1F;
        endcase
    endfunction

    always_comb begin
        zeros    = '0;
        samp_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_q[i]) begin
                zeros    = zeros + 4'd1;
                samp_idx = 3'(i);
            end
        end
    end

    assign samp_ok = zeros == 4'd1;
    assign same    = samp_ok && samp_idx == cand_idx_q && seg_q == cand_seg_q;
    assign dec     = decode(~cand_seg_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q      <= '1;
            an_q       <= '1;
            state_q    <= IDLE;
            cand_seg_q <= '0;
            cand_idx_q <= '0;
            cnt_q      <= '0;
            digits_q   <= '1;
            valid_q    <= '0;
            update_q   <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
        end else begin
            seg_q    <= segments;
            an_q     <= anodes;
            update_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (samp_ok) begin
                        cand_seg_q <= seg_q;
                        cand_idx_q <= samp_idx;
                        cnt_q      <= 8'd1;
                        state_q    <= TRACK;
                    end
                end
                TRACK: begin
                    if (!samp_ok) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (!same) begin
                        cand_seg_q <= seg_q;
                        cand_idx_q <= samp_idx;
                        cnt_q      <= 8'd1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == STABLE) begin
                            for (int i = 0; i < DIGITS; i++) begin
                                if (3'(i) == cand_idx_q) begin
                                    digits_q[4*i +: 4] <= dec[3:0];
                                    valid_q[i]         <= 1'b1;
                                end
                            end
                            update_q <= 1'b1;
                            err_q    <= dec[4];
                            idx_q    <= cand_idx_q;
                            state_q  <= COMMITTED;
                        end
                    end
                end
                default: begin
                    if (!samp_ok) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (!same) begin
                        cand_seg_q <= seg_q;
                        cand_idx_q <= samp_idx;
                        cnt_q      <= 8'd1;
                        state_q    <= TRACK;
                    end else begin
                        cnt_q <= (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign update      = update_q;
    assign update_idx  = idx_q;
    assign err         = err_q;
endmodule

// File: tb/tb_seg_scan_reader.sv
// tb_seg_scan_reader: directed plus randomized checks of seg_scan_reader against a
// run-length behavioural model of the committed display state.
module tb_seg_scan_reader;
    localparam int D  = 4;
    localparam int ST = 4;
    localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [6:0]    segments = '1;
    logic [D-1:0]  anodes = '1;
    logic [4*D-1:0] digits;
    logic [D-1:0]  digit_valid;
    logic          update, err;
    logic [2:0]    update_idx;

    int tests = 0;
    int fails = 0;
    int n_upd = 0;
    int n_err = 0;
    int last_idx = 0;

    seg_scan_reader #(.DIGITS(D), .STABLE_CYCLES(ST)) dut (
        .clk(clk), .reset(reset), .segments(segments), .anodes(anodes),
        .digits(digits), .digit_valid(digit_valid), .update(update),
        .update_idx(update_idx), .err(err)
    );

    always #5 clk = ~clk;

    function automatic bit ok_of(input logic [D-1:0] an);
        return $countones(~an) == 1;
    endfunction

    function automatic int idx_of(input logic [D-1:0] an);
        int r = 0;
        for (int i = 0; i < D; i++) if (!an[i]) r = i;
        return r;
    endfunction

    function automatic logic [4:0] val_of(input logic [6:0] seg);
        logic [4:0] r = 5'h1F;
        for (int v = 0; v < 10; v++) if (~seg == PAT[v]) r = 5'(v);
        return r;
    endfunction

    // model: a commit happens exactly when a valid sample has repeated ST times in a row
    logic [D-1:0]   m_ps_an, m_key_an;
    logic [6:0]     m_ps_seg, m_key_seg;
    int             m_run, nrun;
    logic [4*D-1:0] m_dig;
    logic [D-1:0]   m_val;
    logic           m_upd, m_err;
    logic [2:0]     m_idx;

    always_comb begin
        nrun = 0;
        if (ok_of(m_ps_an))
            nrun = (m_run > 0 && m_ps_an == m_key_an && m_ps_seg == m_key_seg) ? m_run + 1 : 1;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ps_an <= '1; m_ps_seg <= '1; m_key_an <= '1; m_key_seg <= '1;
            m_run <= 0; m_dig <= '1; m_val <= '0; m_upd <= 1'b0; m_err <= 1'b0; m_idx <= '0;
        end else begin
            m_ps_an   <= anodes;
            m_ps_seg  <= segments;
            m_key_an  <= m_ps_an;
            m_key_seg <= m_ps_seg;
            m_run     <= nrun;
            m_upd     <= nrun == ST;
            m_err     <= nrun == ST && val_of(m_ps_seg)[4];
            if (nrun == ST) begin
                m_dig[4*idx_of(m_ps_an) +: 4] <= val_of(m_ps_seg)[3:0];
                m_val[idx_of(m_ps_an)]        <= 1'b1;
                m_idx                         <= 3'(idx_of(m_ps_an));
            end
        end
    end

    always @(negedge clk) begin
        tests++;
        if ({digits, digit_valid, update, update_idx, err} !== {m_dig, m_val, m_upd, m_idx, m_err}) begin
            fails++;
            $display("FAIL model_cmp t=%0t got dig=%h val=%b upd=%b idx=%0d err=%b expected dig=%h val=%b upd=%b idx=%0d err=%b",
                     $time, digits, digit_valid, update, update_idx, err, m_dig, m_val, m_upd, m_idx, m_err);
        end
        if (update) begin
            n_upd++;
            last_idx = int'(update_idx);
        end
        if (err) n_err++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [D-1:0] an, input logic [6:0] seg, input int n);
        anodes   = an;
        segments = seg;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 chk("reset_digits", 32'(digits), 32'hFFFF);
        chk("reset_valid", 32'(digit_valid), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        // single dwell: commit on edge 5 only
        hold(4'b1110, ~7'h5B, 4);
        #1 chk("t1_no_early", 32'(n_upd), 0);
        hold(4'b1110, ~7'h5B, 1);
        #1 chk("t1_pulse_edge5", 32'(update), 32'h1);
        hold(4'b1110, ~7'h5B, 5);
        #1 chk("t1_one_pulse", 32'(n_upd), 1);
        chk("t1_digit0", 32'(digits[3:0]), 32'h2);
        chk("t1_valid", 32'(digit_valid), 32'h1);
        chk("t1_idx", 32'(last_idx), 0);
        chk("t1_err", 32'(n_err), 0);
        // gapless scan of 7,3,9,1
        n_upd = 0;
        hold(4'b1110, ~7'h07, 6);
        hold(4'b1101, ~7'h4F, 6);
        hold(4'b1011, ~7'h6F, 6);
        hold(4'b0111, ~7'h06, 6);
        hold(4'b1111, 7'h7F, 3);
        #1 chk("t2_pulses", 32'(n_upd), 4);
        chk("t2_digits", 32'(digits), 32'h1937);
        chk("t2_model_digits", 32'(m_dig), 32'h1937);
        chk("t2_valid", 32'(digit_valid), 32'hF);
        // blank pattern is illegal
        n_upd = 0; n_err = 0;
        hold(4'b1101, ~7'h00, 5);
        hold(4'b1111, 7'h7F, 2);
        #1 chk("t3_pulse", 32'(n_upd), 1);
        chk("t3_err", 32'(n_err), 1);
        chk("t3_idx", 32'(last_idx), 1);
        chk("t3_digit1", 32'(digits[7:4]), 32'hF);
        // one-cycle glitch restarts the dwell
        n_upd = 0;
        hold(4'b1011, ~7'h7F, 3);
        hold(4'b1011, ~7'h6F, 1);
        hold(4'b1011, ~7'h7F, 3);
        #1 chk("t4_no_commit", 32'(n_upd), 0);
        hold(4'b1011, ~7'h7F, 3);
        #1 chk("t4_commit", 32'(n_upd), 1);
        chk("t4_digit2", 32'(digits[11:8]), 32'h8);
        // two enables low is ignored
        n_upd = 0;
        hold(4'b1100, ~7'h6D, 20);
        hold(4'b1111, 7'h7F, 2);
        #1 chk("t5_no_update", 32'(n_upd), 0);
        chk("t5_digits", 32'(digits), 32'h18F7);
        chk("t5_model_digits", 32'(m_dig), 32'h18F7);
        chk("t5_valid", 32'(digit_valid), 32'hF);
        // async reset mid-dwell then a fresh full dwell
        n_upd = 0;
        hold(4'b1011, ~7'h6D, 2);
        #2 reset = 1'b1;
        #1 chk("t6_rst_digits", 32'(digits), 32'hFFFF);
        chk("t6_rst_valid", 32'(digit_valid), 32'h0);
        chk("t6_rst_outs", {29'd0, update, err, |update_idx}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        hold(4'b1011, ~7'h6D, 4);
        #1 chk("t6_no_early", 32'(n_upd), 0);
        hold(4'b1011, ~7'h6D, 2);
        #1 chk("t6_commit", 32'(n_upd), 1);
        chk("t6_idx", 32'(last_idx), 2);
        chk("t6_digit2", 32'(digits[11:8]), 32'h5);
        // randomized scan, glitches and resets against the model
        for (int k = 0; k < 400; k++) begin
            logic [D-1:0] an;
            logic [6:0] seg;
            an  = ($urandom_range(0, 99) < 80) ? ~(D'(1) << $urandom_range(0, D-1)) : D'($urandom);
            seg = ($urandom_range(0, 99) < 85) ? ~PAT[$urandom_range(0, 9)] : 7'($urandom);
            hold(an, seg, $urandom_range(1, 7));
            if ($urandom_range(0, 99) < 3) begin
                #2 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end
        hold(4'b1111, 7'h7F, 5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
